// File: rtl/alu181_pkg.sv
// Shared types and constants for the nibble-serial 74181 sequencer.
package alu181_pkg;

    localparam int NIB_W = 4;

    localparam logic [3:0] S_ADD    = 4'b1001;
    localparam logic [3:0] S_SUB    = 4'b0110;
    localparam logic [3:0] S_DEC    = 4'b1111;
    localparam logic [3:0] S_XOR_L  = 4'b0110;
    localparam logic [3:0] S_NOTA_L = 4'b0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Observation bundle: sequencer state plus the slice group outputs,
    // which have no functional consumer in a single-slice ripple.
    typedef struct packed {
        state_e state;
        logic   grp_p_n;
        logic   grp_g_n;
    } seq_dbg_t;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 function, active-high data, active-low carries.
module alu181_slice
    import alu181_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cn,
    output logic [NIB_W-1:0] f,
    output logic             p_n,
    output logic             g_n,
    output logic             cn4,
    output logic             a_eq_b
);

    logic [NIB_W-1:0] p;
    logic [NIB_W-1:0] g;
    logic [NIB_W:0]   c;

    // p/g are the two select-gated operand terms; F = p + g + carry in
    // arithmetic mode, and the complemented half-sum in logic mode.
    always_comb begin
        p    = a | (b & {NIB_W{s[0]}}) | (~b & {NIB_W{s[1]}});
        g    = (a & ~b & {NIB_W{s[2]}}) | (a & b & {NIB_W{s[3]}});
        c    = '0;
        c[0] = ~cn;
        for (int i = 0; i < NIB_W; i++) begin
            c[i+1] = g[i] | (p[i] & c[i]);
        end
        f      = m ? ~(p ^ g) : (p ^ g ^ c[NIB_W-1:0]);
        cn4    = ~c[NIB_W];
        a_eq_b = &f;
        p_n    = ~(&p);
        g_n    = ~(g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]));
    end

endmodule

// File: rtl/alu181_nibble_seq.sv
// Runs a W-bit 74181 operation through one slice, LSB nibble first.
// Optional abort input enabled by defining ALU181_NIBBLE_SEQ_ABORT_EN.
module alu181_nibble_seq
    import alu181_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] a,
    input  logic [NIB_W*NIBBLES-1:0] b,
    input  logic [3:0]               s,
    input  logic                     m,
    input  logic                     cn,
`ifdef ALU181_NIBBLE_SEQ_ABORT_EN
    input  logic                     abort,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] f,
    output logic                     cout_n,
    output logic                     a_eq_b,
    output seq_dbg_t                 dbg
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

    // Handshake: start is sampled on a rising edge only while busy=0
    // (IDLE or DONE); busy covers every RUN cycle; done is high for exactly
    // the one cycle in which f/cout_n/a_eq_b first show the new result.

    state_e           state;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_q;
    logic [W-1:0]     b_q;
    logic [W-1:0]     f_q;
    logic [3:0]       s_q;
    logic             m_q;
    logic             carry_q;
    logic             eq_acc;
    logic             cout_q;
    logic             aeq_q;
    logic             busy_q;
    logic             done_q;
    logic             abort_req;

    logic [NIB_W-1:0] sl_a;
    logic [NIB_W-1:0] sl_b;
    logic [NIB_W-1:0] sl_f;
    logic             sl_p_n;
    logic             sl_g_n;
    logic             sl_cn4;
    logic             sl_aeqb;

`ifdef ALU181_NIBBLE_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign sl_a = a_q[NIB_W*idx +: NIB_W];
    assign sl_b = b_q[NIB_W*idx +: NIB_W];

    alu181_slice u_slice (
        .a      (sl_a),
        .b      (sl_b),
        .s      (s_q),
        .m      (m_q),
        .cn     (carry_q),
        .f      (sl_f),
        .p_n    (sl_p_n),
        .g_n    (sl_g_n),
        .cn4    (sl_cn4),
        .a_eq_b (sl_aeqb)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b1;
            eq_acc  <= 1'b1;
            cout_q  <= 1'b1;
            aeq_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        s_q     <= s;
                        m_q     <= m;
                        carry_q <= cn;
                        idx     <= '0;
                        f_q     <= '0;
                        eq_acc  <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        state   <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    // The current nibble is committed even on abort, so an
                    // aborted op leaves every nibble processed so far in f.
                    f_q[NIB_W*idx +: NIB_W] <= sl_f;
                    carry_q <= sl_cn4;
                    eq_acc  <= eq_acc & sl_aeqb;
                    idx     <= idx + IDX_W'(1);
                    if (abort_req) begin
                        busy_q <= 1'b0;
                        state  <= ST_IDLE;
                    end else if (idx == IDX_LAST) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        cout_q <= sl_cn4;
                        aeq_q  <= eq_acc & sl_aeqb;
                        state  <= ST_DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign f      = f_q;
    assign cout_n = cout_q;
    assign a_eq_b = aeq_q;
    assign dbg    = '{state: state, grp_p_n: sl_p_n, grp_g_n: sl_g_n};

endmodule
